// File: rtl/hamming_pkg.sv
// Shared types and constants for the SECDED Hamming(16,11) memory decoder.
package hamming_pkg;

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, CAP, DEC, WR_LO, WR_HI, DONE
  } state_e;

  localparam logic [1:0] FLAG_NONE   = 2'b00;
  localparam logic [1:0] FLAG_SINGLE = 2'b01;
  localparam logic [1:0] FLAG_DOUBLE = 2'b10;

  localparam int SRC_BASE_DEF = 30;
  localparam int DST_BASE_DEF = 0;

endpackage

// File: rtl/secded_core.sv
// Combinational SECDED decode: syndrome/parity check, single-bit correction,
// data extraction from the 16-bit encoded word.
module secded_core
  import hamming_pkg::*;
(
  input  logic [15:0] word_i,
  output logic [10:0] data_o,
  output logic [1:0]  flag_o
);

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fixed;
  logic        unused_par_bits;

  always_comb begin
    syn = '0;
    for (int i = 1; i < 16; i++)
      if (word_i[i]) syn = syn ^ 4'(i);
  end

  assign par = ^word_i;

  // Odd overall parity means one flip; syndrome 0 then points at p0 itself.
  always_comb begin
    fixed  = word_i;
    flag_o = FLAG_NONE;
    if (par) begin
      flag_o = FLAG_SINGLE;
      if (syn != 4'd0) fixed[syn] = ~word_i[syn];
    end else if (syn != 4'd0) begin
      flag_o = FLAG_DOUBLE;
    end
  end

  assign data_o          = {fixed[15:9], fixed[7:5], fixed[3]};
  assign unused_par_bits = ^{fixed[8], fixed[4], fixed[2:0]};

endmodule

// File: rtl/hamming_decoder.sv
// Walks NUM_WORDS encoded words in byte memory, decodes each through
// secded_core and writes data plus error flag back, 6 cycles per word.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = SRC_BASE_DEF,
  parameter int DST_BASE  = DST_BASE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic       done
);

  localparam logic [7:0] SRC8 = 8'(SRC_BASE);
  localparam logic [7:0] DST8 = 8'(DST_BASE);
  localparam logic [7:0] LAST = 8'(NUM_WORDS - 1);

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  lo_q, hi_q;
  logic [10:0] data_q;
  logic [1:0]  flag_q;
  logic [10:0] core_data;
  logic [1:0]  core_flag;
  logic [7:0]  src_lo, dst_lo;

  secded_core u_core (
    .word_i (({hi_q, lo_q})),
    .data_o (core_data),
    .flag_o (core_flag)
  );

  assign src_lo = SRC8 + {idx_q[6:0], 1'b0};
  assign dst_lo = DST8 + {idx_q[6:0], 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d = RD_LO;
        idx_d   = '0;
      end
      RD_LO: state_d = RD_HI;
      RD_HI: state_d = CAP;
      CAP:   state_d = DEC;
      DEC:   state_d = WR_LO;
      WR_LO: state_d = WR_HI;
      WR_HI: if (idx_q < LAST) begin
        state_d = RD_LO;
        idx_d   = idx_q + 8'd1;
      end else begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from state only, so reset clears them in the same cycle.
  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    done        = 1'b0;
    unique case (state_q)
      RD_LO: mem_addr = src_lo;
      RD_HI: mem_addr = src_lo + 8'd1;
      WR_LO: begin
        mem_addr    = dst_lo;
        mem_wr_en   = 1'b1;
        mem_wr_data = data_q[7:0];
      end
      WR_HI: begin
        mem_addr    = dst_lo + 8'd1;
        mem_wr_en   = 1'b1;
        mem_wr_data = {flag_q, 3'b000, data_q[10:8]};
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Read data lags the address by a cycle: low byte lands in RD_HI, high in CAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_q   <= '0;
      hi_q   <= '0;
      data_q <= '0;
      flag_q <= FLAG_NONE;
    end else begin
      if (state_q == RD_HI) lo_q <= mem_rd_data;
      if (state_q == CAP)   hi_q <= mem_rd_data;
      if (state_q == DEC) begin
        data_q <= core_data;
        flag_q <= core_flag;
      end
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder: byte memory model, expected writes
// queued at load time and popped as the DUT writes.
module tb_hamming_decoder;

  localparam int NW  = 15;
  localparam int SRC = 30;
  localparam int DST = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data = '0;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       done;

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t        sb_q[$];
  logic [7:0] src_mem [256];
  int         checks = 0;
  int         failures = 0;

  hamming_decoder #(.NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rd_data <= src_mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("wr_unexpected_addr", 32'(mem_addr), 32'h100);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", 32'(mem_wr_data), 32'(e.d));
      end
    end
  end

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w;
    int j;
    w = '0;
    j = 0;
    for (int pos = 3; pos < 16; pos++)
      if ((pos & (pos - 1)) != 0) begin w[pos] = d[j]; j++; end
    for (int k = 0; k < 4; k++) begin
      logic p;
      p = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if ((pos & (1 << k)) != 0 && pos != (1 << k)) p = p ^ w[pos];
      w[1 << k] = p;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  // Returns {hi, lo} result bytes for one encoded word.
  function automatic logic [15:0] ref_dec(input logic [15:0] w_in);
    logic [15:0] w;
    logic [3:0]  s;
    logic [1:0]  f;
    logic [10:0] d;
    int j;
    w = w_in;
    for (int k = 0; k < 4; k++) begin
      s[k] = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if ((pos & (1 << k)) != 0) s[k] = s[k] ^ w[pos];
    end
    f = 2'b00;
    if (^w) begin
      f = 2'b01;
      if (s != 4'd0) w[s] = ~w[s];
    end else if (s != 4'd0) begin
      f = 2'b10;
    end
    d = '0;
    j = 0;
    for (int pos = 3; pos < 16; pos++)
      if ((pos & (pos - 1)) != 0) begin d[j] = w[pos]; j++; end
    return {f, 3'b000, d[10:8], d[7:0]};
  endfunction

  task automatic load_word(input int i, input logic [15:0] w, input logic [15:0] exp);
    wr_t e;
    src_mem[SRC + 2*i]     = w[7:0];
    src_mem[SRC + 2*i + 1] = w[15:8];
    e.a = 8'(DST + 2*i);     e.d = exp[7:0];  sb_q.push_back(e);
    e.a = 8'(DST + 2*i + 1); e.d = exp[15:8]; sb_q.push_back(e);
  endtask

  task automatic load_run(input bit directed);
    logic [15:0] dir_w [4];
    logic [15:0] dir_e [4];
    dir_w[0] = 16'hFFFF; dir_e[0] = 16'h07FF;
    dir_w[1] = 16'h0020; dir_e[1] = 16'h4000;
    dir_w[2] = 16'hFFFE; dir_e[2] = 16'h47FF;
    dir_w[3] = 16'hFDF7; dir_e[3] = 16'h87EE;
    for (int i = 0; i < NW; i++) begin
      if (directed && i < 4) begin
        load_word(i, dir_w[i], dir_e[i]);
      end else begin
        logic [15:0] w;
        int nf, b1, b2;
        w  = encode(11'($urandom));
        nf = $urandom_range(0, 2);
        b1 = $urandom_range(0, 15);
        b2 = (b1 + 1 + $urandom_range(0, 14)) % 16;
        if (nf >= 1) w[b1] = ~w[b1];
        if (nf == 2) w[b2] = ~w[b2];
        load_word(i, w, ref_dec(w));
      end
    end
  endtask

  // Start pulse, a stray start mid-run that must be ignored, then count to done.
  task automatic do_run(output int n);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("done_after_start", 32'(done), 32'd0);
    n = 1;
    while (n < 200) begin
      @(posedge clk); #1;
      start = (n == 10);
      if (done) break;
      n++;
    end
    start = 1'b0;
  endtask

  initial begin
    int n;
    for (int a = 0; a < 256; a++) src_mem[a] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_wr_data", 32'(mem_wr_data), 32'd0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_addr", 32'(mem_addr), 32'd0);

    load_run(1'b1);
    do_run(n);
    chk("run1_cycles", 32'(n), 32'd90);
    chk("run1_sb_empty", 32'(sb_q.size()), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("done_hold", 32'(done), 32'd1);
    chk("done_addr", 32'(mem_addr), 32'd0);

    load_run(1'b0);
    do_run(n);
    chk("run2_cycles", 32'(n), 32'd90);
    chk("run2_sb_empty", 32'(sb_q.size()), 32'd0);

    load_run(1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_wr_data", 32'(mem_wr_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_addr", 32'(mem_addr), 32'd0);

    load_run(1'b0);
    do_run(n);
    chk("run3_cycles", 32'(n), 32'd90);
    chk("run3_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_decoder.md
HAMMING_DECODER -- requirements
Module: hamming_decoder

Interface
REQ-001 Parameter NUM_WORDS, default 15, number of encoded words processed per run.
REQ-002 Parameter SRC_BASE, default 30, byte address of the first encoded word (low byte).
REQ-003 Parameter DST_BASE, default 0, byte address of the first decoded result (low byte).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a run; sampled only in IDLE or DONE.
REQ-007 mem_addr  output  8  byte address presented to data memory.
REQ-008 mem_rd_data  input  8  read byte, valid the cycle after mem_addr is presented.
REQ-009 mem_wr_en  output  1  write strobe for mem_wr_data at mem_addr.
REQ-010 mem_wr_data  output  8  byte to write.
REQ-011 done  output  1  high while in DONE; run complete.

Function
REQ-012 Encoded word layout SHALL be: bits15:9 = d11:d5, bit8 = p8, bits7:5 = d4:d2, bit4 = p4, bit3 = d1, bit2 = p2, bit1 = p1, bit0 = p0 (overall parity).
REQ-013 Word i SHALL be read as low byte from SRC_BASE+2i and high byte from SRC_BASE+2i+1.
REQ-014 Syndrome s[3:0] SHALL be the XOR of the indices of all set bits in positions 1..15; P SHALL be the XOR of all 16 bits.
REQ-015 P=0, s=0: flag 00, data unchanged.
REQ-016 P=1: flag 01; if s!=0, invert bit s before extraction; if s=0, the error is in p0 and data is unchanged.
REQ-017 P=0, s!=0: flag 10, data extracted uncorrected.
REQ-018 Result for word i SHALL be written as low byte d8:d1 to DST_BASE+2i and high byte {flag, 3'b000, d11:d9} to DST_BASE+2i+1.
REQ-019 FSM states: IDLE, RD_LO, RD_HI, CAP, DEC, WR_LO, WR_HI, DONE.
REQ-020 Transitions: IDLE/DONE --start--> RD_LO (index cleared); RD_LO -> RD_HI -> CAP -> DEC -> WR_LO -> WR_HI; WR_HI -> RD_LO if index < NUM_WORDS-1 (index incremented), else DONE.
REQ-021 Each state SHALL last exactly one cycle, giving 6 cycles per word and 90 cycles from start to done for the default parameters.
REQ-022 RD_HI SHALL capture the low byte and CAP SHALL capture the high byte; DEC SHALL register the corrected data and flag.
REQ-023 mem_wr_en SHALL be high only in WR_LO and WR_HI; mem_addr SHALL be 0 in IDLE and DONE.
REQ-024 start SHALL be ignored in RD_LO through WR_HI; start in DONE SHALL drop done on the next cycle and begin a new run.
REQ-025 done SHALL remain high until start or reset.

Reset
REQ-026 Reset low SHALL immediately force state IDLE, index 0, done 0, mem_wr_en 0, mem_addr 0, mem_wr_data 0, and clear all capture registers.
REQ-027 Reset asserted mid-run SHALL abandon the run without further writes; memory already written SHALL be left as-is.
REQ-028 After reset release the block SHALL remain in IDLE until start.

Structure
REQ-029 The state enum, the flag encodings (FLAG_NONE = 00, FLAG_SINGLE = 01, FLAG_DOUBLE = 10) and the default base addresses SHALL live in a shared package, hamming_pkg.
REQ-030 Decode logic (16-bit word in; 11-bit data and 2-bit flag out) SHALL be a purely combinational sub-module, secded_core, instantiated once.

Verification
REQ-031 Clean word 0xFFFF at SRC_BASE -> writes lo 0xFF, hi 0x07 (flag 00).
REQ-032 Word 0x0020 (0x0000 with bit 5 flipped) -> writes lo 0x00, hi 0x40 (single error corrected).
REQ-033 Word 0xFFFE (p0 flipped) -> writes lo 0xFF, hi 0x47.
REQ-034 Word 0xFDF7 (0xFFFF with bits 3 and 9 flipped) -> writes lo 0xEE, hi 0x87 (flag 10, data uncorrected).
REQ-035 Full run of 15 random encoded words with 0, 1 or 2 flips -> all 30 result bytes match the reference model, and done rises exactly 90 cycles after start.
REQ-036 Reset pulled low 20 cycles into a run -> done 0 and mem_wr_en 0 in the same cycle; the next start performs a complete, correct run.
